// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite manager: one command in, one AXI-Lite transaction out, response buffered
// until consumed. Zero-wait latency: cmd accept N -> rsp_valid N+3; new commands stall while a response is held.
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic                  busy,
    output logic                  timeout_pulse,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_AW_W,
        S_WR_B,
        S_RD_AR,
        S_RD_R
    } state_t;

    state_t                  r_state;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [CNT_W-1:0]        r_wd_cnt;
    logic                    r_timeout_pulse;

    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic                    r_awvalid;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic                    r_wvalid;
    logic                    r_bready;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic                    r_arvalid;
    logic                    r_rready;

    logic                    r_rsp_valid;
    logic                    r_rsp_write;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_resp;

    logic w_cmd_ready;
    logic w_cmd_hs;
    logic w_rsp_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_wd_tick;

    // cmd_ready looks at the registered rsp_valid, so a command offered in the
    // same cycle the response is consumed waits one more cycle.
    assign w_cmd_ready = (r_state == S_IDLE) && !r_rsp_valid && !m_axi_areset;
    assign w_cmd_hs    = cmd_valid && w_cmd_ready;
    assign w_rsp_hs    = r_rsp_valid && rsp_ready;
    assign w_aw_hs     = r_awvalid && m_axi_awready;
    assign w_w_hs      = r_wvalid && m_axi_wready;
    assign w_aw_fin    = r_aw_done || w_aw_hs;
    assign w_w_fin     = r_w_done || w_w_hs;
    assign w_b_hs      = r_bready && m_axi_bvalid;
    assign w_ar_hs     = r_arvalid && m_axi_arready;
    assign w_r_hs      = r_rready && m_axi_rvalid;
    assign w_wd_tick   = ((r_state == S_WR_B) && !w_b_hs) || ((r_state == S_RD_R) && !w_r_hs);

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_state         <= S_IDLE;
            r_aw_done       <= 1'b0;
            r_w_done        <= 1'b0;
            r_wd_cnt        <= '0;
            r_timeout_pulse <= 1'b0;
            r_awaddr        <= '0;
            r_awvalid       <= 1'b0;
            r_wdata         <= '0;
            r_wstrb         <= '0;
            r_wvalid        <= 1'b0;
            r_bready        <= 1'b0;
            r_araddr        <= '0;
            r_arvalid       <= 1'b0;
            r_rready        <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_write     <= 1'b0;
            r_rsp_rdata     <= '0;
            r_rsp_resp      <= 2'b00;
        end else begin
            r_timeout_pulse <= 1'b0;

            if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
            end

            // Watchdog saturates at the limit so it fires only once per wait.
            if (w_wd_tick && (r_wd_cnt != CNT_MAX)) begin
                r_wd_cnt        <= r_wd_cnt + 1'b1;
                r_timeout_pulse <= (r_wd_cnt == CNT_PRE);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        if (cmd_write) begin
                            r_state   <= S_WR_AW_W;
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else begin
                            r_state   <= S_RD_AR;
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                        end
                    end
                end

                S_WR_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_state  <= S_WR_B;
                        r_awaddr <= '0;
                        r_wdata  <= '0;
                        r_wstrb  <= '0;
                        r_bready <= 1'b1;
                        r_wd_cnt <= '0;
                    end
                end

                S_WR_B: begin
                    if (w_b_hs) begin
                        r_state     <= S_IDLE;
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= m_axi_bresp;
                    end
                end

                S_RD_AR: begin
                    if (w_ar_hs) begin
                        r_state   <= S_RD_R;
                        r_arvalid <= 1'b0;
                        r_araddr  <= '0;
                        r_rready  <= 1'b1;
                        r_wd_cnt  <= '0;
                    end
                end

                S_RD_R: begin
                    if (w_r_hs) begin
                        r_state     <= S_IDLE;
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b0;
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_resp  <= m_axi_rresp;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = w_cmd_ready;
    assign busy          = (r_state != S_IDLE);
    assign timeout_pulse = r_timeout_pulse;

    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;

    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural AXI-Lite slave with per-channel wait states,
// response scoreboard, and monitors for valid widths, address stability and the watchdog.
module tb_axi_lite_master;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          areset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          busy, timeout_pulse;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [SW-1:0] m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi_lite_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy), .timeout_pulse(timeout_pulse),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_rsp   = 0;
    int   rsp_cyc = 0;

    // slave configuration and state
    int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]    b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [DW-1:0] r_data_cfg = '0;
    logic          aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, ar_got;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int            b_hs_cnt = 0;
    logic [AW-1:0] log_awaddr, log_araddr;
    logic [DW-1:0] log_wdata;
    logic [SW-1:0] log_wstrb;

    // monitor state
    int            aw_hi = 0, w_hi = 0, aw_unstable = 0, to_cnt = 0, to_cyc = 0, bready_rise = 0;
    logic          prev_awvalid = 1'b0, prev_bready = 1'b0;
    logic [AW-1:0] prev_awaddr = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rsp_t mk(input logic wr, input logic [DW-1:0] rd, input logic [1:0] rs);
        rsp_t r;
        r.wr    = wr;
        r.rdata = rd;
        r.resp  = rs;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave: decisions at the falling edge, so a ready raised here completes at the next rising edge.
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            if (areset) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
                aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (aw_fire) begin aw_got = 1; aw_fire = 0; aw_cnt = 0; end
                if (w_fire)  begin w_got = 1;  w_fire = 0;  w_cnt = 0;  end
                if (b_fire)  begin m_axi_bvalid = 0; m_axi_bresp = 0; b_fire = 0; aw_got = 0; w_got = 0; b_cnt = 0; end
                if (ar_fire) begin ar_got = 1; ar_fire = 0; ar_cnt = 0; end
                if (r_fire)  begin m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; r_fire = 0; ar_got = 0; r_cnt = 0; end

                m_axi_awready = 0;
                if (m_axi_awvalid) begin
                    if (aw_cnt >= aw_dly) begin m_axi_awready = 1; aw_fire = 1; log_awaddr = m_axi_awaddr; end
                    else aw_cnt++;
                end
                m_axi_wready = 0;
                if (m_axi_wvalid) begin
                    if (w_cnt >= w_dly) begin
                        m_axi_wready = 1; w_fire = 1; log_wdata = m_axi_wdata; log_wstrb = m_axi_wstrb;
                    end else w_cnt++;
                end
                m_axi_arready = 0;
                if (m_axi_arvalid) begin
                    if (ar_cnt >= ar_dly) begin m_axi_arready = 1; ar_fire = 1; log_araddr = m_axi_araddr; end
                    else ar_cnt++;
                end
                if (aw_got && w_got && !m_axi_bvalid) begin
                    if (b_cnt >= b_dly) begin m_axi_bvalid = 1; m_axi_bresp = b_resp_cfg; end
                    else b_cnt++;
                end
                if (m_axi_bvalid && m_axi_bready) begin b_fire = 1; b_hs_cnt++; end
                if (ar_got && !m_axi_rvalid) begin
                    if (r_cnt >= r_dly) begin m_axi_rvalid = 1; m_axi_rdata = r_data_cfg; m_axi_rresp = r_resp_cfg; end
                    else r_cnt++;
                end
                if (m_axi_rvalid && m_axi_rready) r_fire = 1;
            end
        end
    end

    // Monitor and scoreboard consumer
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!areset) begin
                if (m_axi_awvalid) aw_hi++;
                if (m_axi_wvalid) w_hi++;
                if (m_axi_awvalid && prev_awvalid && (m_axi_awaddr != prev_awaddr)) aw_unstable++;
                if (m_axi_bready && !prev_bready) bready_rise = cyc;
                if (timeout_pulse) begin to_cnt++; to_cyc = cyc; end
                if (rsp_valid && rsp_ready) begin
                    rsp_cyc = cyc + 1;
                    n_rsp++;
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_write", 64'(rsp_write), 64'(e.wr));
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                    end
                end
            end
            prev_awvalid = m_axi_awvalid;
            prev_awaddr  = m_axi_awaddr;
            prev_bready  = m_axi_bready;
        end
    end

    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [SW-1:0] strb, input rsp_t exp, output int acc);
        logic rdy;
        exp_q.push_back(exp);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        acc = -1;
        for (int n = 0; n < 200; n++) begin
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        cmd_valid = 0;
        if (acc < 0) chk("cmd_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input int prev, input int budget);
        bit ok;
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            if (n_rsp > prev) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("rsp_wait_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int acc, prev, b0;
        areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_timeout", 64'(timeout_pulse), 64'd0);
        chk("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        chk("rst_wdata", 64'(m_axi_wdata), 64'd0);
        areset = 0;
        #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // back-to-back writes, zero-wait slave
        rsp_ready = 1;
        for (int i = 1; i <= 5; i++) begin
            prev = n_rsp;
            send(1'b1, AW'(i), 32'h1111_0000 + DW'(i), 4'hF, mk(1'b1, '0, 2'b00), acc);
            wait_rsp(prev, 20);
            chk("t1_latency", 64'(rsp_cyc - acc), 64'd3);
            chk("t1_awaddr", 64'(log_awaddr), 64'(i));
            chk("t1_wdata", 64'(log_wdata), 64'(32'h1111_0000 + i));
            chk("t1_wstrb", 64'(log_wstrb), 64'hF);
        end

        // AW stalled 3 cycles, W immediate
        aw_dly = 3; aw_hi = 0; w_hi = 0; aw_unstable = 0; b0 = b_hs_cnt; prev = n_rsp;
        send(1'b1, 6'h02, 32'hA5A5_A5A5, 4'hF, mk(1'b1, '0, 2'b00), acc);
        wait_rsp(prev, 40);
        chk("t2_aw_high", 64'(aw_hi), 64'd4);
        chk("t2_w_high", 64'(w_hi), 64'd1);
        chk("t2_aw_stable", 64'(aw_unstable), 64'd0);
        chk("t2_b_count", 64'(b_hs_cnt - b0), 64'd1);
        chk("t2_awaddr", 64'(log_awaddr), 64'h02);
        chk("t2_wdata", 64'(log_wdata), 64'hA5A5_A5A5);
        aw_dly = 0;

        // read with response held off by the consumer
        r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = 2'b00; rsp_ready = 0;
        send(1'b0, 6'h04, '0, '0, mk(1'b0, 32'hDEAD_BEEF, 2'b00), acc);
        for (int n = 0; n < 20 && !rsp_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("t3_araddr", 64'(log_araddr), 64'h04);
        for (int n = 0; n < 5; n++) begin
            chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("t3_rdata_hold", 64'(rsp_rdata), 64'hDEAD_BEEF);
            chk("t3_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("t3_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
        end
        // command offered in the same cycle the response is consumed
        rsp_ready = 1;
        send(1'b1, 6'h06, 32'h0BAD_F00D, 4'h3, mk(1'b1, '0, 2'b00), acc);
        chk("t3_accept_after_rsp", 64'(acc), 64'(rsp_cyc + 1));
        prev = n_rsp;
        wait_rsp(prev, 20);
        chk("t3_wstrb", 64'(log_wstrb), 64'h3);

        // watchdog: bvalid withheld 20 cycles, then SLVERR
        b_dly = 20; b_resp_cfg = 2'b10; to_cnt = 0; prev = n_rsp;
        send(1'b1, 6'h08, 32'h5555_AAAA, 4'hF, mk(1'b1, '0, 2'b10), acc);
        wait_rsp(prev, 100);
        chk("t4_timeout_count", 64'(to_cnt), 64'd1);
        chk("t4_timeout_delay", 64'(to_cyc - bready_rise), 64'd16);
        b_dly = 0; b_resp_cfg = 2'b00;

        // reset mid-write abandons the transaction
        aw_dly = 4;
        send(1'b1, 6'h0A, 32'h7777_7777, 4'hF, mk(1'b1, '0, 2'b00), acc);
        @(posedge clk); #1;
        areset = 1;
        @(posedge clk); #1;
        chk("t5_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("t5_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("t5_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("t5_bready", 64'(m_axi_bready), 64'd0);
        chk("t5_rready", 64'(m_axi_rready), 64'd0);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_awaddr", 64'(m_axi_awaddr), 64'd0);
        exp_q.delete();
        areset = 0; aw_dly = 0;
        #1;
        chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        r_data_cfg = 32'h1234_5678; prev = n_rsp;
        send(1'b0, 6'h03, '0, '0, mk(1'b0, 32'h1234_5678, 2'b00), acc);
        wait_rsp(prev, 20);
        chk("t5_latency", 64'(rsp_cyc - acc), 64'd3);
        chk("t5_araddr", 64'(log_araddr), 64'h03);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
